// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed common-anode 7-segment scanner with frame-synchronous shadowed display data.
// Latency: AN/SEGMENT are one register after pres/idx/display; new data is shown from the next frame boundary.
// Backpressure: none; data_vld is always accepted, and the last strobe before a boundary wins. SEG7_DIM_EN adds PWM dimming.
module seg7_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 131072,
  parameter int BLANK_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] hexs,
  input  logic [DIGITS-1:0]   points,
  input  logic [DIGITS-1:0]   LEs,
`ifdef SEG7_DIM_EN
  input  logic [3:0]          bright,
`endif
  input  logic                data_vld,
  output logic                upd_ack,
  output logic                frame_start,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          SEGMENT
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRES_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // One captured set of display inputs.
  typedef struct packed {
    logic [DIGITS-1:0][3:0] hex;
    logic [DIGITS-1:0]      pts;
    logic [DIGITS-1:0]      les;
  } disp_t;

  logic [PW-1:0]     pres;
  logic [IW-1:0]     idx;
  logic              frame_end;
  logic              dead;
  logic              lit;
  logic              pend_flag;
  disp_t             in_d;
  disp_t             pend;
  disp_t             disp;
  logic [DIGITS-1:0] an_nxt;
  logic [7:0]        seg_nxt;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign in_d      = {hexs, points, LEs};
  assign frame_end = (pres == PRES_LAST) && (idx == IDX_LAST);

  // Dead time covers the first BLANK_CYC cycles of every digit slot.
  if (BLANK_CYC > 0) begin : g_blank
    assign dead = (pres < PW'(BLANK_CYC));
  end else begin : g_noblank
    assign dead = 1'b0;
  end

`ifdef SEG7_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase; the digit is lit while the phase is at or below bright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= 4'd0;
    else      pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign lit = (pwm_cnt <= bright);
`else
  assign lit = 1'b1;
`endif

  // Scan prescaler and digit index; idx advances when a slot completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pres <= '0;
      idx  <= '0;
    end else if (pres == PRES_LAST) begin
      pres <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pres <= pres + 1'b1;
    end
  end

  // Pending/display shadowing: display only moves at the frame boundary; a strobe on the boundary cycle bypasses pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend        <= '0;
      disp        <= '0;
      pend_flag   <= 1'b0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      upd_ack     <= 1'b0;
      if (frame_end) begin
        if (data_vld) begin
          disp      <= in_d;
          pend_flag <= 1'b0;
          upd_ack   <= 1'b1;
        end else if (pend_flag) begin
          disp      <= pend;
          pend_flag <= 1'b0;
          upd_ack   <= 1'b1;
        end
      end else if (data_vld) begin
        pend      <= in_d;
        pend_flag <= 1'b1;
      end
    end
  end

  // Next AN/SEGMENT: at most one anode low, everything off during dead time or PWM off phase.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (!dead && lit) begin
      an_nxt[idx] = 1'b0;
      if (!disp.les[idx]) begin
        seg_nxt = {~disp.pts[idx], ~seg7(disp.hex[idx])};
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN      <= '1;
      SEGMENT <= 8'hFF;
    end else begin
      AN      <= an_nxt;
      SEGMENT <= seg_nxt;
    end
  end

endmodule
